// File: rtl/wb_snoop_responder_pkg.sv
// Shared snoop definitions: type codes, FSM encodings and counter helper.
// Used by the snoop responder and the snoop arbiter.
package wb_snoop_responder_pkg;

    localparam logic SNOOP_IDLE = 1'b0;
    localparam logic SNOOP_READ = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_READ = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/wb_snoop_responder.sv
// Snoop responder: looks up a snooped address in the cache's shared RAM
// read port and returns hit/data with a four-phase type/ack handshake.
module wb_snoop_responder
    import wb_snoop_responder_pkg::*;
#(
    parameter int aw             = 32,
    parameter int dw             = 32,
    parameter int set_width      = 4,
    parameter int line_width     = 4,
    parameter bit hit_dirty_only = 1'b0
) (
    input  logic                                wb_clk_i,
    input  logic                                wb_rst_i,
    input  logic [aw-1:0]                       snoop_adr_i,
    input  logic                                snoop_type_i,
    output logic                                snoop_ack_o,
    output logic                                snoop_hit_o,
    output logic [dw-1:0]                       snoop_dat_o,
    output logic                                ram_req_o,
    input  logic                                ram_gnt_i,
    output logic [set_width-1:0]                ram_idx_o,
    output logic [set_width+line_width-3:0]     ram_widx_o,
    input  logic [aw-set_width-line_width-1:0]  ram_tag_i,
    input  logic                                ram_valid_i,
    input  logic                                ram_dirty_i,
    input  logic [dw-1:0]                       ram_dat_i,
    output logic [15:0]                         snoop_hits_o
);

    localparam int ib = line_width + set_width;

    logic [1:0]    state_q;
    logic [aw-1:0] adr_q;
    logic          hit_q;
    logic [dw-1:0] dat_q;
    logic [15:0]   hits_q;
    logic          hit_d;
    logic          in_resp;
    logic          unused_ofs;

    // Byte offset within a word never reaches the RAM.
    assign unused_ofs = ^adr_q[1:0];

    assign hit_d = ram_valid_i
                && (ram_tag_i == adr_q[aw-1:ib])
                && (!hit_dirty_only || ram_dirty_i);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            hit_q   <= 1'b0;
            dat_q   <= '0;
            hits_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (snoop_type_i == SNOOP_READ) begin
                        adr_q   <= snoop_adr_i;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (snoop_type_i == SNOOP_IDLE)
                        state_q <= ST_IDLE;
                    else if (ram_gnt_i)
                        state_q <= ST_READ;
                end
                ST_READ: begin
                    if (snoop_type_i == SNOOP_IDLE) begin
                        state_q <= ST_IDLE;
                    end else begin
                        // Miss returns zero data rather than stale RAM contents.
                        hit_q   <= hit_d;
                        dat_q   <= hit_d ? ram_dat_i : '0;
                        if (hit_d)
                            hits_q <= sat_inc(hits_q);
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (snoop_type_i == SNOOP_IDLE)
                        state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_resp      = (state_q == ST_RESP);
    assign snoop_ack_o  = in_resp;
    assign snoop_hit_o  = in_resp & hit_q;
    assign snoop_dat_o  = in_resp ? dat_q : '0;
    assign snoop_hits_o = hits_q;

    // Request is withdrawn as soon as the snooper abandons the lookup.
    assign ram_req_o  = (state_q == ST_REQ) && (snoop_type_i == SNOOP_READ);
    assign ram_idx_o  = adr_q[ib-1:line_width];
    assign ram_widx_o = adr_q[ib-1:2];

endmodule
